// File: rtl/loadable_instruction_memory.sv
// rtl/loadable_instruction_memory.sv - loadable word-array instruction memory with byte-stream load sequencer
// Optional fetch bounds check is enabled by defining IMEM_BOUNDS_CHECK_EN.
module loadable_instruction_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Address,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  fetch_valid,
    output logic                  fetch_fault,
    output logic                  cpu_stall,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  load_abort,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  load_done
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH:0]     wr_ptr;
    logic [ADDR_WIDTH:0]     wr_ptr_inc;
    logic [ADDR_WIDTH:0]     eff_len;
    logic [ADDR_WIDTH:0]     start_len;
    logic [1:0]              byte_cnt;
    logic [23:0]             word_buf;
    logic                    byte_fire;
    logic                    word_fire;
    logic                    mem_we;
    logic                    fetch_en;
    logic                    addr_bad;
    logic [ADDR_WIDTH-1:0]   rd_idx;

    assign start_len  = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    assign wr_ptr_inc = wr_ptr + 1'b1;
    assign byte_fire  = rx_valid && rx_ready;
    assign word_fire  = byte_fire && (byte_cnt == 2'd3);
    // An abort wins over a simultaneous final byte: that word is dropped.
    assign mem_we     = word_fire && !load_abort;
    assign rd_idx     = Address[ADDR_WIDTH+1:2];
    assign fetch_en   = (state == IDLE) && (state_next == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cpu_stall  = 1'b0;
        rx_ready   = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = (start_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                cpu_stall = 1'b1;
                rx_ready  = 1'b1;
                if (load_abort) begin
                    state_next = IDLE;
                end else if (word_fire && (wr_ptr_inc == eff_len)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cpu_stall  = 1'b1;
                load_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bytes shift in from the top, so after three bytes word_buf = {b2, b1, b0}.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            eff_len  <= '0;
            byte_cnt <= 2'd0;
            word_buf <= '0;
        end else if (state == IDLE) begin
            if (load_start) begin
                wr_ptr   <= '0;
                eff_len  <= start_len;
                byte_cnt <= 2'd0;
            end
        end else if (state == LOAD) begin
            if (load_abort) begin
                byte_cnt <= 2'd0;
            end else if (byte_fire) begin
                word_buf <= {rx_byte, word_buf[23:8]};
                byte_cnt <= byte_cnt + 2'd1;
                if (word_fire) begin
                    wr_ptr <= wr_ptr_inc;
                end
            end
        end
    end

    // Array is deliberately not reset so a loaded program survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {rx_byte, word_buf};
        end
    end

`ifdef IMEM_BOUNDS_CHECK_EN
    assign addr_bad = (Address[1:0] != 2'b00) || ((Address >> (ADDR_WIDTH + 2)) != 32'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_fault <= 1'b0;
        end else begin
            fetch_fault <= fetch_en && addr_bad;
        end
    end
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};
    assign addr_bad         = 1'b0;
    assign fetch_fault      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Instruction <= '0;
            fetch_valid <= 1'b0;
        end else if (fetch_en) begin
            Instruction <= addr_bad ? '0 : mem[rd_idx];
            fetch_valid <= 1'b1;
        end else begin
            Instruction <= '0;
            fetch_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_loadable_instruction_memory.sv
// tb/tb_loadable_instruction_memory.sv - randomized self-checking bench for loadable_instruction_memory
module tb_loadable_instruction_memory;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int LIMIT = 20000;

    typedef logic [7:0] bytes_t[$];

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   Address = 32'd0;
    logic [31:0]   Instruction;
    logic          fetch_valid;
    logic          fetch_fault;
    logic          cpu_stall;
    logic          load_start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          load_abort = 1'b0;
    logic [7:0]    rx_byte = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          load_done;

    int n_pass  = 0;
    int n_total = 0;

    loadable_instruction_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .Address     (Address),
        .Instruction (Instruction),
        .fetch_valid (fetch_valid),
        .fetch_fault (fetch_fault),
        .cpu_stall   (cpu_stall),
        .load_start  (load_start),
        .load_len    (load_len),
        .load_abort  (load_abort),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .load_done   (load_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 loading, 2 done; bytes gathered in a queue.
    int           m_ph = 0;
    int           m_tgt = 0;
    int           m_cnt = 0;
    logic [7:0]   m_q[$];
    logic [31:0]  mmem [DEPTH];
    bit           known [DEPTH];
    logic [31:0]  e_instr = 32'd0;
    logic         e_valid = 1'b0;
    logic         e_fault = 1'b0;
    bit           e_known = 1'b0;

    always @(posedge clk or negedge reset) begin
        int nph;
        int idx;
        if (!reset) begin
            m_ph    = 0;
            e_instr = 32'd0;
            e_valid = 1'b0;
            e_fault = 1'b0;
            m_q.delete();
        end else begin
            nph = m_ph;
            if (m_ph == 0) begin
                if (load_start) begin
                    m_tgt = (int'(load_len) > DEPTH) ? DEPTH : int'(load_len);
                    m_cnt = 0;
                    m_q.delete();
                    nph = (m_tgt == 0) ? 2 : 1;
                end
            end else if (m_ph == 1) begin
                if (load_abort) begin
                    m_q.delete();
                    nph = 0;
                end else if (rx_valid) begin
                    m_q.push_back(rx_byte);
                    if (m_q.size() == 4) begin
                        mmem[m_cnt]  = {m_q[3], m_q[2], m_q[1], m_q[0]};
                        known[m_cnt] = 1'b1;
                        m_cnt++;
                        m_q.delete();
                        if (m_cnt == m_tgt) nph = 2;
                    end
                end
            end else begin
                nph = 0;
            end
            if (m_ph == 0 && nph == 0) begin
                idx     = int'((Address / 4) % DEPTH);
                e_valid = 1'b1;
                e_fault = 1'b0;
                e_instr = mmem[idx];
                e_known = known[idx];
`ifdef IMEM_BOUNDS_CHECK_EN
                if ((Address % 4) != 0 || Address >= 4 * DEPTH) begin
                    e_instr = 32'd0;
                    e_fault = 1'b1;
                end
`endif
            end else begin
                e_valid = 1'b0;
                e_fault = 1'b0;
                e_instr = 32'd0;
            end
            m_ph = nph;
        end
    end

    always @(negedge clk) begin
        check("cpu_stall",   32'(cpu_stall),   32'(m_ph != 0));
        check("rx_ready",    32'(rx_ready),    32'(m_ph == 1));
        check("load_done",   32'(load_done),   32'(m_ph == 2));
        check("fetch_valid", 32'(fetch_valid), 32'(e_valid));
        check("fetch_fault", 32'(fetch_fault), 32'(e_fault));
        if (!e_valid || e_fault || e_known) begin
            check("Instruction", Instruction, e_instr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bytes_t rand_bytes(input int n);
        bytes_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // period 0: random gaps; period n: one byte every n cycles. abort_at < 0: no abort.
    task automatic do_load(input int len, input bytes_t bytes, input int period,
                           input int abort_at, output int done_cnt);
        int sent  = 0;
        int guard = 0;
        done_cnt   = 0;
        load_start = 1'b1;
        load_len   = (AW + 1)'(len);
        tick();
        load_start = 1'b0;
        while (cpu_stall && guard < LIMIT) begin
            if (load_done) done_cnt++;
            if (abort_at >= 0 && sent == abort_at) begin
                load_abort = 1'b1;
                rx_valid   = ($urandom_range(0, 1) == 1);
                rx_byte    = 8'($urandom);
                tick();
                load_abort = 1'b0;
                rx_valid   = 1'b0;
                abort_at   = -1;
            end else begin
                if (period == 0) rx_valid = (sent < bytes.size()) && ($urandom_range(0, 3) != 0);
                else             rx_valid = (sent < bytes.size()) && (guard % period == 0);
                rx_byte = rx_valid ? bytes[sent] : 8'($urandom);
                if (rx_valid && rx_ready) sent++;
                tick();
                rx_valid = 1'b0;
            end
            guard++;
        end
        check("load_finished", 32'(cpu_stall), 32'd0);
    endtask

    task automatic fetch_rand(input int n);
        for (int i = 0; i < n; i++) begin
            Address = ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, DEPTH - 1)) << 2);
            tick();
        end
    endtask

    initial begin
        bytes_t      b;
        int          dc;
        int          len;
        int          eff;
        logic [31:0] w1;

        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr", Instruction, 32'd0);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        reset = 1'b1;
        check("release_valid", 32'(fetch_valid), 32'd0);
        tick();
        check("first_fetch_valid", 32'(fetch_valid), 32'd1);

        b = {8'h08, 8'h00, 8'h04, 8'h20, 8'hFF, 8'hFF, 8'h00, 8'h10};
        do_load(2, b, 1, -1, dc);
        check("plan_done_pulse", 32'(dc), 32'd1);
        check("model_word0", mmem[0], 32'h20040008);
        check("model_word1", mmem[1], 32'h1000FFFF);
        Address = 32'd4;
        tick();
        check("fetch_addr4", Instruction, 32'h1000FFFF);
        Address = 32'h400;
        tick();
`ifdef IMEM_BOUNDS_CHECK_EN
        check("addr_400_instr", Instruction, 32'd0);
        check("addr_400_fault", 32'(fetch_fault), 32'd1);
`else
        check("addr_400_instr", Instruction, 32'h20040008);
        check("addr_400_fault", 32'(fetch_fault), 32'd0);
`endif
        Address = 32'h402;
        tick();
`ifdef IMEM_BOUNDS_CHECK_EN
        check("addr_402_instr", Instruction, 32'd0);
        check("addr_402_fault", 32'(fetch_fault), 32'd1);
`else
        check("addr_402_instr", Instruction, 32'h20040008);
`endif

        b = rand_bytes(12);
        do_load(3, b, 1, 6, dc);
        check("abort_no_done", 32'(dc), 32'd0);
        Address = 32'd0;
        tick();
        check("abort_word0", Instruction, {b[3], b[2], b[1], b[0]});
        Address = 32'd4;
        tick();
        check("abort_word1_kept", Instruction, 32'h1000FFFF);

        load_start = 1'b1;
        load_len   = '0;
        tick();
        load_start = 1'b0;
        check("zero_len_done", 32'(load_done), 32'd1);
        check("zero_len_rx_ready", 32'(rx_ready), 32'd0);
        tick();
        check("zero_len_stall_drop", 32'(cpu_stall), 32'd0);

        b = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_load(2, b, 3, -1, dc);
        check("gap_done_pulse", 32'(dc), 32'd1);
        Address = 32'd0;
        tick();
        check("gap_word0", Instruction, 32'h44332211);
        Address = 32'd4;
        tick();
        check("gap_word1", Instruction, 32'h88776655);

        b = rand_bytes(4 * DEPTH);
        do_load(300, b, 0, -1, dc);
        check("full_done_pulse", 32'(dc), 32'd1);
        fetch_rand(200);

        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(0, 12);
            eff = len;
            b   = rand_bytes(4 * eff);
            do_load(len, b, 0, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * eff) : -1, dc);
            fetch_rand(20);
        end

        w1 = mmem[1];
        b  = rand_bytes(6);
        load_start = 1'b1;
        load_len   = (AW + 1)'(3);
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1;
            rx_byte  = b[i];
            tick();
        end
        rx_valid = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check("midload_reset_stall", 32'(cpu_stall), 32'd0);
        check("midload_reset_valid", 32'(fetch_valid), 32'd0);
        tick();
        reset   = 1'b1;
        Address = 32'd0;
        tick();
        check("reset_word0_kept", Instruction, {b[3], b[2], b[1], b[0]});
        Address = 32'd4;
        tick();
        check("reset_word1_kept", Instruction, w1);
        fetch_rand(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
